// File: rtl/mips_pipe_pkg.sv
// Shared definitions for the MIPS pipeline stages: default widths,
// control-vector bit positions and the MEM/WB stage state encoding.
package mips_pipe_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;
  localparam int CTRL_W_DEF     = 3;
  localparam int CNT_W_DEF      = 16;

  localparam int CTRL_JAL      = 0;
  localparam int CTRL_REGWRITE = 1;
  localparam int CTRL_MEMTOREG = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } stage_state_e;

endpackage

// File: rtl/pipe_slot.sv
// One storage slot of the MEM/WB stage: valid bit plus ctrl/data/register fields.
// Clear wins over load and only drops the valid bit; the fields keep stale data.
module pipe_slot
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CTRL_W     = CTRL_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  clr_i,
  input  logic                  load_i,
  input  logic [CTRL_W-1:0]     ctrl_d_i,
  input  logic [DATA_W-1:0]     ram_d_i,
  input  logic [DATA_W-1:0]     alu_d_i,
  input  logic [REG_ADDR_W-1:0] wreg_d_i,
  output logic                  valid_o,
  output logic [CTRL_W-1:0]     ctrl_o,
  output logic [DATA_W-1:0]     ram_o,
  output logic [DATA_W-1:0]     alu_o,
  output logic [REG_ADDR_W-1:0] wreg_o
);

  logic                  valid_q;
  logic [CTRL_W-1:0]     ctrl_q;
  logic [DATA_W-1:0]     ram_q;
  logic [DATA_W-1:0]     alu_q;
  logic [REG_ADDR_W-1:0] wreg_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      ctrl_q  <= '0;
      ram_q   <= '0;
      alu_q   <= '0;
      wreg_q  <= '0;
    end else if (clr_i) begin
      valid_q <= 1'b0;
    end else if (load_i) begin
      valid_q <= 1'b1;
      ctrl_q  <= ctrl_d_i;
      ram_q   <= ram_d_i;
      alu_q   <= alu_d_i;
      wreg_q  <= wreg_d_i;
    end
  end

  assign valid_o = valid_q;
  assign ctrl_o  = ctrl_q;
  assign ram_o   = ram_q;
  assign alu_o   = alu_q;
  assign wreg_o  = wreg_q;

endmodule

// File: rtl/mem_wb_pipe_stage.sv
// MEM->WB pipeline stage with valid/ready handshake, 2-entry skid buffer,
// synchronous flush and a saturating writeback stall counter.
//
// state | meaning
// EMPTY | no entry held, out_valid low
// ONE   | main slot holds the head entry
// FULL  | main slot holds head, skid slot holds the next entry; in_ready low
module mem_wb_pipe_stage
  import mips_pipe_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF,
  parameter int CTRL_W     = CTRL_W_DEF,
  parameter int CNT_W      = CNT_W_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [CTRL_W-1:0]     in_ctrl,
  input  logic [DATA_W-1:0]     in_ram_read_data,
  input  logic [DATA_W-1:0]     in_alu_result,
  input  logic [REG_ADDR_W-1:0] in_write_register,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CTRL_W-1:0]     out_ctrl,
  output logic [DATA_W-1:0]     out_ram_read_data,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [REG_ADDR_W-1:0] out_write_register,
  output logic [1:0]            occupancy,
  output logic [CNT_W-1:0]      stall_count
);

  stage_state_e state_q, state_d;
  logic [CNT_W-1:0] stall_q;

  logic push, pop;
  logic main_load, main_clr, main_from_skid;
  logic skid_load, skid_clr;

  logic                  main_vld, skid_vld;
  logic [CTRL_W-1:0]     main_ctrl, skid_ctrl, main_ctrl_d;
  logic [DATA_W-1:0]     main_ram, skid_ram, main_ram_d;
  logic [DATA_W-1:0]     main_alu, skid_alu, main_alu_d;
  logic [REG_ADDR_W-1:0] main_wreg, skid_wreg, main_wreg_d;

  assign in_ready = (state_q != FULL);
  assign push     = in_valid & in_ready;
  assign pop      = main_vld & out_ready;

  always_comb begin
    state_d        = state_q;
    main_load      = 1'b0;
    main_clr       = flush;
    main_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clr       = flush;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: begin
          if (push) begin
            main_load = 1'b1;
            state_d   = ONE;
          end
        end
        ONE: begin
          if (push && pop) begin
            main_load = 1'b1;
          end else if (push) begin
            skid_load = 1'b1;
            state_d   = FULL;
          end else if (pop) begin
            main_clr = 1'b1;
            state_d  = EMPTY;
          end
        end
        FULL: begin
          if (pop) begin
            main_load      = 1'b1;
            main_from_skid = 1'b1;
            skid_clr       = 1'b1;
            state_d        = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  assign main_ctrl_d = main_from_skid ? skid_ctrl : in_ctrl;
  assign main_ram_d  = main_from_skid ? skid_ram  : in_ram_read_data;
  assign main_alu_d  = main_from_skid ? skid_alu  : in_alu_result;
  assign main_wreg_d = main_from_skid ? skid_wreg : in_write_register;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= EMPTY;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      // Profiling counter survives flush; it only stops at all-ones.
      if (main_vld && !out_ready && !(&stall_q))
        stall_q <= stall_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  pipe_slot #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W)) u_main (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (main_clr),
    .load_i   (main_load),
    .ctrl_d_i (main_ctrl_d),
    .ram_d_i  (main_ram_d),
    .alu_d_i  (main_alu_d),
    .wreg_d_i (main_wreg_d),
    .valid_o  (main_vld),
    .ctrl_o   (main_ctrl),
    .ram_o    (main_ram),
    .alu_o    (main_alu),
    .wreg_o   (main_wreg)
  );

  pipe_slot #(.DATA_W(DATA_W), .REG_ADDR_W(REG_ADDR_W), .CTRL_W(CTRL_W)) u_skid (
    .clk      (clk),
    .reset    (reset),
    .clr_i    (skid_clr),
    .load_i   (skid_load),
    .ctrl_d_i (in_ctrl),
    .ram_d_i  (in_ram_read_data),
    .alu_d_i  (in_alu_result),
    .wreg_d_i (in_write_register),
    .valid_o  (skid_vld),
    .ctrl_o   (skid_ctrl),
    .ram_o    (skid_ram),
    .alu_o    (skid_alu),
    .wreg_o   (skid_wreg)
  );

  // Bubbles must never carry RegWrite/MemToReg/Jal into writeback.
  assign out_valid          = main_vld;
  assign out_ctrl           = main_vld ? main_ctrl : '0;
  assign out_ram_read_data  = main_ram;
  assign out_alu_result     = main_alu;
  assign out_write_register = main_wreg;
  assign occupancy          = {skid_vld, main_vld & ~skid_vld};
  assign stall_count        = stall_q;

endmodule

// File: tb/tb_mem_wb_pipe_stage.sv
// Self-checking bench for mem_wb_pipe_stage: directed scenarios plus random
// traffic compared against a 2-deep FIFO queue model.
module tb_mem_wb_pipe_stage;

  typedef struct packed {
    logic [2:0]  ctrl;
    logic [31:0] ram;
    logic [31:0] alu;
    logic [4:0]  wr;
  } ent_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        flush;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_ctrl;
  logic [31:0] in_ram_read_data;
  logic [31:0] in_alu_result;
  logic [4:0]  in_write_register;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  out_ctrl;
  logic [31:0] out_ram_read_data;
  logic [31:0] out_alu_result;
  logic [4:0]  out_write_register;
  logic [1:0]  occupancy;
  logic [15:0] stall_count;

  int n_checks = 0;
  int n_fail   = 0;

  ent_t        q[$];
  int unsigned m_stall = 0;

  always #5 clk = ~clk;

  mem_wb_pipe_stage dut (
    .clk                (clk),
    .reset              (reset),
    .flush              (flush),
    .in_valid           (in_valid),
    .in_ready           (in_ready),
    .in_ctrl            (in_ctrl),
    .in_ram_read_data   (in_ram_read_data),
    .in_alu_result      (in_alu_result),
    .in_write_register  (in_write_register),
    .out_valid          (out_valid),
    .out_ready          (out_ready),
    .out_ctrl           (out_ctrl),
    .out_ram_read_data  (out_ram_read_data),
    .out_alu_result     (out_alu_result),
    .out_write_register (out_write_register),
    .occupancy          (occupancy),
    .stall_count        (stall_count)
  );

  task automatic drive(input logic v, input logic [31:0] alu);
    in_valid          = v;
    in_alu_result     = alu;
    in_ctrl           = 3'($urandom_range(0, 7));
    in_ram_read_data  = $urandom;
    in_write_register = 5'($urandom_range(0, 31));
  endtask

  // Advance one clock and update the queue model from the inputs seen at the edge.
  task automatic tick();
    ent_t e, d;
    bit do_push, do_pop, do_flush;
    @(negedge clk);
    do_flush = flush;
    do_push  = in_valid && (q.size() < 2);
    do_pop   = (q.size() > 0) && out_ready;
    e = '{ctrl: in_ctrl, ram: in_ram_read_data, alu: in_alu_result, wr: in_write_register};
    if (q.size() > 0 && !out_ready && m_stall < 65535) m_stall++;
    @(posedge clk);
    #1;
    if (do_flush) q.delete();
    else begin
      if (do_pop) d = q.pop_front();
      if (do_push) q.push_back(e);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0; flush = 1'b0; out_ready = 1'b0;
    in_valid = 1'b1; in_ctrl = 3'b111; in_ram_read_data = 32'h1234_5678;
    in_alu_result = 32'hCAFE_F00D; in_write_register = 5'd7;
    repeat (3) @(posedge clk);
    #1;
    n_checks++;
    if ({out_valid, out_ctrl, occupancy, in_ready, stall_count} !== {1'b0, 3'b000, 2'd0, 1'b1, 16'd0}) begin
      n_fail++;
      $display("FAIL reset_state: got valid=%b ctrl=%b occ=%0d ready=%b stall=%0d, want 0 000 0 1 0",
               out_valid, out_ctrl, occupancy, in_ready, stall_count);
    end
    @(negedge clk);
    in_valid = 1'b0;
    reset = 1'b1;
    q.delete(); m_stall = 0;
    @(posedge clk); #1;
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL reset_release_idle: got valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_stream();
    logic [31:0] vals [3];
    vals[0] = 32'h10; vals[1] = 32'h20; vals[2] = 32'h30;
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, vals[i]);
      tick();
      n_checks++;
      if (out_valid !== 1'b1 || out_alu_result !== vals[i] || occupancy !== 2'd1
          || out_ctrl !== q[0].ctrl || out_ram_read_data !== q[0].ram || out_write_register !== q[0].wr) begin
        n_fail++;
        $display("FAIL stream_%0d: got valid=%b alu=%h occ=%0d ctrl=%b, want 1 %h 1 %b",
                 i, out_valid, out_alu_result, occupancy, out_ctrl, vals[i], q[0].ctrl);
      end
    end
    in_valid = 1'b0;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 3'b000) begin
      n_fail++;
      $display("FAIL stream_drain: got valid=%b occ=%0d ctrl=%b, want 0 0 000", out_valid, occupancy, out_ctrl);
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] exp_heads [3];
    exp_heads[0] = 32'hA; exp_heads[1] = 32'hB; exp_heads[2] = 32'hC;
    out_ready = 1'b0;
    drive(1'b1, 32'hA); tick();
    drive(1'b1, 32'hB); tick();
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_alu_result !== 32'hA) begin
      n_fail++;
      $display("FAIL bp_full: got occ=%0d ready=%b head=%h, want 2 0 a", occupancy, in_ready, out_alu_result);
    end
    drive(1'b1, 32'hC); tick();
    n_checks++;
    if (occupancy !== 2'd2 || in_ready !== 1'b0 || out_alu_result !== 32'hA) begin
      n_fail++;
      $display("FAIL bp_hold_upstream: got occ=%0d ready=%b head=%h, want 2 0 a", occupancy, in_ready, out_alu_result);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      n_checks++;
      if (out_valid !== 1'b1 || out_alu_result !== exp_heads[i]) begin
        n_fail++;
        $display("FAIL bp_order_%0d: got valid=%b head=%h, want 1 %h", i, out_valid, out_alu_result, exp_heads[i]);
      end
      tick();
      if (i == 1) in_valid = 1'b0;
    end
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL bp_no_duplicate: got valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  task automatic test_flush();
    out_ready = 1'b0;
    drive(1'b1, 32'hF1); in_ctrl = 3'b011; tick();
    drive(1'b1, 32'hF2); in_ctrl = 3'b110; tick();
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL flush_prefill: got occ=%0d, want 2", occupancy);
    end
    flush = 1'b1;
    drive(1'b1, 32'hDEAD); in_ctrl = 3'b111;
    tick();
    n_checks++;
    if (occupancy !== 2'd0 || out_valid !== 1'b0 || out_ctrl !== 3'b000 || in_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL flush_empty: got occ=%0d valid=%b ctrl=%b ready=%b, want 0 0 000 1",
               occupancy, out_valid, out_ctrl, in_ready);
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0 || out_ctrl !== 3'b000) begin
      n_fail++;
      $display("FAIL flush_input_dropped: got valid=%b occ=%0d alu=%h, want nothing valid",
               out_valid, occupancy, out_alu_result);
    end
  endtask

  task automatic test_random();
    int sz;
    logic [1:0] exp_occ;
    logic [2:0] exp_ctrl;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 3) != 0), $urandom);
      out_ready = 1'($urandom_range(0, 2) != 0);
      flush     = ($urandom_range(0, 29) == 0);
      tick();
      sz       = q.size();
      exp_occ  = sz[1:0];
      exp_ctrl = (sz > 0) ? q[0].ctrl : 3'b000;
      n_checks++;
      if ({out_valid, in_ready, occupancy, out_ctrl} !== {(sz > 0), (sz < 2), exp_occ, exp_ctrl}) begin
        n_fail++;
        $display("FAIL rand_ctrl_%0d: got valid=%b ready=%b occ=%0d ctrl=%b, want %b %b %0d %b",
                 i, out_valid, in_ready, occupancy, out_ctrl, (sz > 0), (sz < 2), exp_occ, exp_ctrl);
      end
      if (sz > 0) begin
        n_checks++;
        if ({out_ram_read_data, out_alu_result, out_write_register} !== {q[0].ram, q[0].alu, q[0].wr}) begin
          n_fail++;
          $display("FAIL rand_data_%0d: got ram=%h alu=%h wr=%0d, want %h %h %0d",
                   i, out_ram_read_data, out_alu_result, out_write_register, q[0].ram, q[0].alu, q[0].wr);
        end
      end
      n_checks++;
      if (stall_count !== 16'(m_stall)) begin
        n_fail++;
        $display("FAIL rand_stall_%0d: got %0d, want %0d", i, stall_count, m_stall);
      end
    end
    flush = 1'b0;
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (3) tick();
  endtask

  task automatic test_stall_counter();
    out_ready = 1'b0;
    drive(1'b1, 32'h5A5A); tick();
    in_valid = 1'b0;
    for (int i = 0; i < 70000; i++) begin
      tick();
      if (i == 100) begin
        n_checks++;
        if (stall_count !== 16'(m_stall)) begin
          n_fail++;
          $display("FAIL stall_midway: got %0d, want %0d", stall_count, m_stall);
        end
      end
    end
    n_checks++;
    if (stall_count !== 16'hFFFF || m_stall != 65535) begin
      n_fail++;
      $display("FAIL stall_saturate: got %h, want ffff", stall_count);
    end
    n_checks++;
    if (out_valid !== 1'b1 || out_alu_result !== 32'h5A5A) begin
      n_fail++;
      $display("FAIL stall_entry_kept: got valid=%b alu=%h, want 1 5a5a", out_valid, out_alu_result);
    end
  endtask

  task automatic test_async_reset();
    out_ready = 1'b0;
    drive(1'b1, 32'h77); tick();
    n_checks++;
    if (occupancy !== 2'd2) begin
      n_fail++;
      $display("FAIL areset_prefill: got occ=%0d, want 2", occupancy);
    end
    in_valid = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_checks++;
    if ({out_valid, out_ctrl, occupancy, in_ready, stall_count} !== {1'b0, 3'b000, 2'd0, 1'b1, 16'd0}) begin
      n_fail++;
      $display("FAIL areset_immediate: got valid=%b ctrl=%b occ=%0d ready=%b stall=%0d, want 0 000 0 1 0",
               out_valid, out_ctrl, occupancy, in_ready, stall_count);
    end
    q.delete(); m_stall = 0;
    @(negedge clk);
    reset = 1'b1;
    out_ready = 1'b1;
    tick();
    n_checks++;
    if (out_valid !== 1'b0 || occupancy !== 2'd0) begin
      n_fail++;
      $display("FAIL areset_no_writeback: got valid=%b occ=%0d, want 0 0", out_valid, occupancy);
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_flush();
    test_random();
    test_stall_counter();
    test_async_reset();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
